// File: rtl/axi4_lite_slave_mem.sv
`default_nettype none
// axi4_lite_slave_mem: AXI4-Lite slave over a word-addressed 32-bit register memory.
// Independent write and read FSMs; every output is driven from a register.
module axi4_lite_slave_mem #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DEPTH      = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_awaddr,
  input  logic [3:0]            s_awcache,
  input  logic [2:0]            s_awprot,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [31:0]           s_wdata,
  input  logic [3:0]            s_wstrb,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic [3:0]            s_arcache,
  input  logic [2:0]            s_arprot,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [31:0]           s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rvalid,
  input  logic                  s_rready
);

  localparam int         IDX_W       = $clog2(DEPTH);
  localparam int         LSB         = IDX_W + 2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [31:0] mem [DEPTH];

  w_state_t              w_state, w_state_n;
  r_state_t              r_state, r_state_n;
  logic                  aw_held, aw_held_n, w_held, w_held_n;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;
  logic                  awready_q, awready_n, wready_q, wready_n, arready_q, arready_n;
  logic                  bvalid_q, bvalid_n, rvalid_q, rvalid_n;
  logic [1:0]            bresp_q, bresp_n, rresp_q, rresp_n;
  logic [31:0]           rdata_q, rdata_n;
  logic                  wr_commit;

  // A handshake this cycle counts as already held, so AW and W may land on the same edge.
  logic                  aw_hs, w_hs, ar_hs, aw_have, w_have;
  logic [ADDR_WIDTH-1:0] awaddr_eff;
  logic [31:0]           wdata_eff;
  logic [3:0]            wstrb_eff;
  logic                  wr_hit, rd_hit;
  logic [IDX_W-1:0]      wr_idx, rd_idx;

  assign aw_hs      = s_awvalid && awready_q;
  assign w_hs       = s_wvalid && wready_q;
  assign ar_hs      = s_arvalid && arready_q;
  assign aw_have    = aw_held || aw_hs;
  assign w_have     = w_held || w_hs;
  assign awaddr_eff = aw_hs ? s_awaddr : awaddr_q;
  assign wdata_eff  = w_hs ? s_wdata : wdata_q;
  assign wstrb_eff  = w_hs ? s_wstrb : wstrb_q;

  // BASE_ADDR is aligned to the memory size, so the upper bits alone decide the hit.
  assign wr_hit = (awaddr_eff[ADDR_WIDTH-1:LSB] == BASE_ADDR[ADDR_WIDTH-1:LSB]);
  assign wr_idx = awaddr_eff[LSB-1:2];
  assign rd_hit = (s_araddr[ADDR_WIDTH-1:LSB] == BASE_ADDR[ADDR_WIDTH-1:LSB]);
  assign rd_idx = s_araddr[LSB-1:2];

  logic unused_bits;
  assign unused_bits = &{1'b0, s_awcache, s_awprot, s_arcache, s_arprot,
                         awaddr_eff[1:0], s_araddr[1:0]};

  always_comb begin
    w_state_n = w_state;
    aw_held_n = aw_held;
    w_held_n  = w_held;
    awready_n = awready_q;
    wready_n  = wready_q;
    bvalid_n  = bvalid_q;
    bresp_n   = bresp_q;
    wr_commit = 1'b0;
    case (w_state)
      W_IDLE: begin
        aw_held_n = aw_have;
        w_held_n  = w_have;
        if (aw_have && w_have) begin
          wr_commit = 1'b1;
          bvalid_n  = 1'b1;
          bresp_n   = wr_hit ? RESP_OKAY : RESP_SLVERR;
          awready_n = 1'b0;
          wready_n  = 1'b0;
          w_state_n = W_RESP;
        end else begin
          awready_n = !aw_have;
          wready_n  = !w_have;
        end
      end
      W_RESP: begin
        if (bvalid_q && s_bready) begin
          bvalid_n  = 1'b0;
          aw_held_n = 1'b0;
          w_held_n  = 1'b0;
          awready_n = 1'b1;
          wready_n  = 1'b1;
          w_state_n = W_IDLE;
        end
      end
      default: w_state_n = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_n = r_state;
    arready_n = arready_q;
    rvalid_n  = rvalid_q;
    rdata_n   = rdata_q;
    rresp_n   = rresp_q;
    case (r_state)
      R_IDLE: begin
        arready_n = 1'b1;
        if (ar_hs) begin
          rdata_n   = rd_hit ? mem[rd_idx] : 32'h0;
          rresp_n   = rd_hit ? RESP_OKAY : RESP_SLVERR;
          rvalid_n  = 1'b1;
          arready_n = 1'b0;
          r_state_n = R_DATA;
        end
      end
      R_DATA: begin
        if (rvalid_q && s_rready) begin
          rvalid_n  = 1'b0;
          arready_n = 1'b1;
          r_state_n = R_IDLE;
        end
      end
      default: r_state_n = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state   <= W_IDLE;
      r_state   <= R_IDLE;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      w_state   <= w_state_n;
      r_state   <= r_state_n;
      aw_held   <= aw_held_n;
      w_held    <= w_held_n;
      awaddr_q  <= awaddr_eff;
      wdata_q   <= wdata_eff;
      wstrb_q   <= wstrb_eff;
      awready_q <= awready_n;
      wready_q  <= wready_n;
      arready_q <= arready_n;
      bvalid_q  <= bvalid_n;
      bresp_q   <= bresp_n;
      rvalid_q  <= rvalid_n;
      rresp_q   <= rresp_n;
      rdata_q   <= rdata_n;
    end
  end

  // Memory is deliberately not reset; a commit coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst && wr_commit && wr_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_eff[i]) mem[wr_idx][8*i +: 8] <= wdata_eff[8*i +: 8];
      end
    end
  end

  assign s_awready = awready_q;
  assign s_wready  = wready_q;
  assign s_arready = arready_q;
  assign s_bvalid  = bvalid_q;
  assign s_bresp   = bresp_q;
  assign s_rvalid  = rvalid_q;
  assign s_rresp   = rresp_q;
  assign s_rdata   = rdata_q;

endmodule
`default_nettype wire
